// File: rtl/osc_period_meter.sv
// Ring-oscillator period meter: enables the oscillator, lets it settle, then counts
// synchronized rising edges of osc_in over a fixed window of clk cycles.
module osc_period_meter #(
  parameter int unsigned GATE_CYCLES   = 100,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             osc_in,
  output logic             osc_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_count,
  output logic             overflow,
  output logic             stuck
);

  localparam int unsigned MaxCyc = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CW     = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  typedef enum logic [1:0] {StIdle, StSettle, StMeasure, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sync1_q, sync2_q, prev_q;
  logic             rise;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             stuck_q, stuck_d;
  logic             osc_en_q, osc_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  assign rise = sync2_q & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= osc_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    stuck_d    = stuck_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StSettle;
          cnt_d      = CW'(SETTLE_CYCLES - 1);
          count_d    = '0;
          overflow_d = 1'b0;
          stuck_d    = 1'b0;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StMeasure;
          cnt_d   = CW'(GATE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StMeasure: begin
        if (rise) begin
          if (&count_q) begin
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        // The last window cycle's edge is already folded into count_d here.
        if (cnt_q == '0) begin
          state_d = StDone;
          stuck_d = (count_d == '0);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    osc_en_d = (state_d == StSettle) || (state_d == StMeasure);
    busy_d   = (state_d != StIdle);
    done_d   = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      stuck_q    <= 1'b0;
      osc_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      stuck_q    <= stuck_d;
      osc_en_q   <= osc_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign osc_en     = osc_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign edge_count = count_q;
  assign overflow   = overflow_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_osc_period_meter.sv
// Directed bench for osc_period_meter: default-width unit plus a 4-bit unit that
// shares clk/rst_n/start and sees a faster oscillator to exercise saturation.
module tb_osc_period_meter;

  localparam int CLK_P = 10;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       osc_in;
  logic       osc_en, busy, done, overflow, stuck;
  logic [7:0] edge_count;
  logic       osc4;
  logic       osc_en4, busy4, done4, overflow4, stuck4;
  logic [3:0] edge_count4;

  int checks   = 0;
  int failures = 0;
  int osc_half = 5;

  // Results of the last measure() call.
  int ndone, en_cnt, first_en, last_en, busy106;
  int done_cyc[2];
  int cnt_rec[2];
  int ov_rec, st_rec, cnt4_rec, ov4_rec, st4_rec;

  osc_period_meter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .osc_in     (osc_in),
    .osc_en     (osc_en),
    .busy       (busy),
    .done       (done),
    .edge_count (edge_count),
    .overflow   (overflow),
    .stuck      (stuck)
  );

  osc_period_meter #(.CNT_W(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .osc_in     (osc4),
    .osc_en     (osc_en4),
    .busy       (busy4),
    .done       (done4),
    .edge_count (edge_count4),
    .overflow   (overflow4),
    .stuck      (stuck4)
  );

  initial clk = 1'b0;
  always #(CLK_P / 2) clk = ~clk;

  // Main oscillator: half period osc_half clk periods, or held low when 0.
  initial begin
    osc_in = 1'b0;
    #3;
    forever begin
      if (osc_half == 0) begin
        osc_in = 1'b0;
        #(CLK_P);
      end else begin
        #(osc_half * CLK_P) osc_in = ~osc_in;
      end
    end
  end

  // Period-4 oscillator for the 4-bit unit.
  initial begin
    osc4 = 1'b0;
    #7;
    forever #(2 * CLK_P) osc4 = ~osc4;
  end

  initial begin
    #(100000 * CLK_P);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Called at a negedge with the DUT idle; that cycle is cycle 0.
  task automatic measure(input int pulse_a, input int pulse_b, input int limit);
    ndone = 0; en_cnt = 0; first_en = -1; last_en = -1; busy106 = -1;
    done_cyc[0] = -1; done_cyc[1] = -1; cnt_rec[0] = -1; cnt_rec[1] = -1;
    start = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (osc_en) begin
        en_cnt++;
        if (first_en < 0) first_en = c;
        last_en = c;
      end
      if (c == 106) busy106 = int'(busy);
      if (done) begin
        if (ndone < 2) begin
          done_cyc[ndone] = c;
          cnt_rec[ndone]  = int'(edge_count);
        end
        if (ndone == 0) begin
          ov_rec = int'(overflow); st_rec = int'(stuck);
          cnt4_rec = int'(edge_count4); ov4_rec = int'(overflow4); st4_rec = int'(stuck4);
        end
        ndone++;
      end
      start = (c == pulse_a) || (c == pulse_b);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({osc_en, busy, done, overflow, stuck} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 00000", {osc_en, busy, done, overflow, stuck});
    end
    checks++;
    if (edge_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_count: got %0d expected 0", edge_count);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_normal;
    measure(0, 0, 115);
    checks++;
    if (ndone !== 1 || done_cyc[0] !== 105) begin
      failures++;
      $display("FAIL normal_done: got n=%0d cyc=%0d expected n=1 cyc=105", ndone, done_cyc[0]);
    end
    checks++;
    if (cnt_rec[0] !== 10 || ov_rec !== 0 || st_rec !== 0) begin
      failures++;
      $display("FAIL normal_result: got cnt=%0d ov=%0d st=%0d expected 10 0 0",
               cnt_rec[0], ov_rec, st_rec);
    end
    checks++;
    if (en_cnt !== 104 || first_en !== 1 || last_en !== 104) begin
      failures++;
      $display("FAIL normal_osc_en: got n=%0d first=%0d last=%0d expected 104 1 104",
               en_cnt, first_en, last_en);
    end
    checks++;
    if (busy106 !== 0) begin
      failures++;
      $display("FAIL normal_busy_idle: got %0d expected 0", busy106);
    end
  endtask

  task automatic test_hold;
    repeat (30) @(negedge clk);
    checks++;
    if (edge_count !== 8'd10 || overflow !== 1'b0 || stuck !== 1'b0) begin
      failures++;
      $display("FAIL hold_after_done: got cnt=%0d ov=%0d st=%0d expected 10 0 0",
               edge_count, overflow, stuck);
    end
  endtask

  task automatic test_stuck;
    osc_half = 0;
    repeat (20) @(negedge clk);
    measure(0, 0, 115);
    checks++;
    if (ndone !== 1 || done_cyc[0] !== 105) begin
      failures++;
      $display("FAIL stuck_done: got n=%0d cyc=%0d expected n=1 cyc=105", ndone, done_cyc[0]);
    end
    checks++;
    if (cnt_rec[0] !== 0 || ov_rec !== 0 || st_rec !== 1) begin
      failures++;
      $display("FAIL stuck_result: got cnt=%0d ov=%0d st=%0d expected 0 0 1",
               cnt_rec[0], ov_rec, st_rec);
    end
    osc_half = 5;
    repeat (30) @(negedge clk);
    checks++;
    if (edge_count !== 8'd0 || overflow !== 1'b0 || stuck !== 1'b1) begin
      failures++;
      $display("FAIL stuck_hold: got cnt=%0d ov=%0d st=%0d expected 0 0 1",
               edge_count, overflow, stuck);
    end
  endtask

  task automatic test_overflow;
    measure(0, 0, 115);
    checks++;
    if (cnt4_rec !== 15 || ov4_rec !== 1 || st4_rec !== 0) begin
      failures++;
      $display("FAIL overflow_result: got cnt=%0d ov=%0d st=%0d expected 15 1 0",
               cnt4_rec, ov4_rec, st4_rec);
    end
    checks++;
    if (cnt_rec[0] !== 10) begin
      failures++;
      $display("FAIL overflow_wide_unit: got %0d expected 10", cnt_rec[0]);
    end
  endtask

  task automatic test_start_ignore;
    measure(50, 105, 200);
    checks++;
    if (ndone !== 1 || done_cyc[0] !== 105 || cnt_rec[0] !== 10) begin
      failures++;
      $display("FAIL start_ignored: got n=%0d cyc=%0d cnt=%0d expected 1 105 10",
               ndone, done_cyc[0], cnt_rec[0]);
    end
  endtask

  task automatic test_back_to_back;
    measure(106, 0, 230);
    checks++;
    if (ndone !== 2 || done_cyc[0] !== 105 || done_cyc[1] !== 211) begin
      failures++;
      $display("FAIL b2b_done: got n=%0d c0=%0d c1=%0d expected 2 105 211",
               ndone, done_cyc[0], done_cyc[1]);
    end
    checks++;
    if (cnt_rec[1] !== 10) begin
      failures++;
      $display("FAIL b2b_count: got %0d expected 10", cnt_rec[1]);
    end
  endtask

  task automatic test_reset_mid;
    int nd;
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1 || osc_en !== 1'b1) begin
      failures++;
      $display("FAIL mid_before_reset: got busy=%b en=%b expected 1 1", busy, osc_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({osc_en, busy, done, overflow, stuck} !== 5'b0 || edge_count !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset_clear: got flags=%b cnt=%0d expected 00000 0",
               {osc_en, busy, done, overflow, stuck}, edge_count);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++;
    if (nd !== 0) begin
      failures++;
      $display("FAIL mid_no_done: got %0d expected 0", nd);
    end
    measure(0, 0, 115);
    checks++;
    if (ndone !== 1 || done_cyc[0] !== 105 || cnt_rec[0] !== 10) begin
      failures++;
      $display("FAIL mid_recover: got n=%0d cyc=%0d cnt=%0d expected 1 105 10",
               ndone, done_cyc[0], cnt_rec[0]);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_hold();
    test_stuck();
    test_overflow();
    test_start_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
